// File: rtl/slot_glyph_pkg.sv
// Glyph constants and symbol indices shared by the slot display driver and its receive-side decoder.
package slot_glyph_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SYM_W      = 3;
  localparam int unsigned SEG_W      = 8;

  // Slot symbol indices as carried on the sym bus.
  typedef enum logic [SYM_W-1:0] {
    SYM_T = 3'd0,
    SYM_C = 3'd1,
    SYM_P = 3'd2,
    SYM_L = 3'd3,
    SYM_N = 3'd4,
    SYM_O = 3'd5,
    SYM_H = 3'd6,
    SYM_E = 3'd7
  } sym_e;

  // Active-low segment patterns {dp,g..a}. The decimal point is always off.
  localparam logic [SEG_W-1:0] GLYPH_T = 8'h87;
  localparam logic [SEG_W-1:0] GLYPH_C = 8'hC6;
  localparam logic [SEG_W-1:0] GLYPH_P = 8'h8C;
  localparam logic [SEG_W-1:0] GLYPH_L = 8'hC7;
  localparam logic [SEG_W-1:0] GLYPH_N = 8'hAB;
  localparam logic [SEG_W-1:0] GLYPH_O = 8'hC0;
  localparam logic [SEG_W-1:0] GLYPH_H = 8'h89;
  localparam logic [SEG_W-1:0] GLYPH_E = 8'h86;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_BLANK  = 4'hF;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic             known;
    logic [SYM_W-1:0] idx;
  } glyph_dec_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-symbol decoder; exact 8-bit match, anything else is unknown.
module seg_glyph_decode
  import slot_glyph_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output glyph_dec_t       dec_c
);

  // Full-pattern lookup of the eight slot glyphs.
  always_comb begin
    dec_c       = '0;
    dec_c.known = 1'b1;
    case (seg)
      GLYPH_T: dec_c.idx = SYM_T;
      GLYPH_C: dec_c.idx = SYM_C;
      GLYPH_P: dec_c.idx = SYM_P;
      GLYPH_L: dec_c.idx = SYM_L;
      GLYPH_N: dec_c.idx = SYM_N;
      GLYPH_O: dec_c.idx = SYM_O;
      GLYPH_H: dec_c.idx = SYM_H;
      GLYPH_E: dec_c.idx = SYM_E;
      default: dec_c.known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: waits for each anode dwell to settle,
// samples one glyph per dwell, keeps per-digit symbol/stability state and flags full frames.
module seg_scan_decoder
  import slot_glyph_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STABLE_SCANS  = 3
) (
  input  logic                        basys_clk,
  input  logic                        reset_n,
  input  logic [NUM_DIGITS-1:0]       an,
  input  logic [SEG_W-1:0]            seg,
  input  logic                        err_clr,
  output logic [NUM_DIGITS*SYM_W-1:0] sym,
  output logic [NUM_DIGITS-1:0]       sym_valid,
  output logic [NUM_DIGITS-1:0]       digit_stable,
  output logic                        frame_done,
  output logic                        anode_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned STB_W = $clog2(STABLE_SCANS + 1);

  // True when exactly one anode is driven low.
  function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] a);
    logic [NUM_DIGITS-1:0] n;
    n = ~a;
    return (n != '0) && ((n & (n - NUM_DIGITS'(1))) == '0);
  endfunction

  logic [NUM_DIGITS-1:0] in_an_q;
  logic [SEG_W-1:0]      in_seg_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sampled_q, sampled_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  frame_done_q, frame_done_d;
  logic                  anode_err_q, anode_err_d;

  logic                  an_chg_c;
  logic                  an_bad_c;
  logic                  sample_c;
  logic [NUM_DIGITS-1:0] samp_dig_c;
  glyph_dec_t            dec_c;

  // Single decoder on the registered segment bus, shared by all digit slices.
  seg_glyph_decode u_dec (
    .seg   (in_seg_q),
    .dec_c (dec_c)
  );

  // Dwell tracking, sample strobe, frame mask and anode error next-state.
  always_comb begin
    an_d         = an_q;
    cnt_d        = cnt_q;
    sampled_d    = sampled_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    anode_err_d  = anode_err_q;

    an_chg_c   = (in_an_q != an_q);
    an_bad_c   = !onehot_low(in_an_q) && (in_an_q != AN_BLANK);
    // An anode change in the same cycle suppresses the sample.
    sample_c   = !an_chg_c && !sampled_q && onehot_low(an_q) &&
                 (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    samp_dig_c = sample_c ? ~an_q : '0;

    if (an_chg_c) begin
      an_d      = in_an_q;
      cnt_d     = '0;
      sampled_d = 1'b0;
    end else begin
      if (cnt_q != CNT_W'(SETTLE_CYCLES)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (sample_c) begin
        sampled_d = 1'b1;
      end
    end

    // A sample arriving while the full mask clears starts the next frame.
    if (seen_q == '1) begin
      frame_done_d = 1'b1;
      seen_d       = samp_dig_c;
    end else begin
      seen_d = seen_q | samp_dig_c;
    end

    // A fresh invalid anode outranks a simultaneous clear.
    if (an_bad_c) begin
      anode_err_d = 1'b1;
    end else if (err_clr) begin
      anode_err_d = 1'b0;
    end
  end

  // Input registers and shared scan state.
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_an_q      <= AN_BLANK;
      in_seg_q     <= SEG_BLANK;
      an_q         <= AN_BLANK;
      cnt_q        <= '0;
      sampled_q    <= 1'b0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      anode_err_q  <= 1'b0;
    end else begin
      in_an_q      <= an;
      in_seg_q     <= seg;
      an_q         <= an_d;
      cnt_q        <= cnt_d;
      sampled_q    <= sampled_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      anode_err_q  <= anode_err_d;
    end
  end

  assign frame_done = frame_done_q;
  assign anode_err  = anode_err_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             vld_q, vld_d;
    logic [STB_W-1:0] stc_q, stc_d;
    logic             stb_q, stb_d;

    // Per-digit symbol update and repeat-count tracking on this digit's sample.
    always_comb begin
      sym_d = sym_q;
      vld_d = vld_q;
      stc_d = stc_q;
      if (samp_dig_c[g]) begin
        if (dec_c.known) begin
          sym_d = dec_c.idx;
          vld_d = 1'b1;
          if (vld_q && (sym_q == dec_c.idx)) begin
            if (stc_q != STB_W'(STABLE_SCANS)) begin
              stc_d = stc_q + STB_W'(1);
            end
          end else begin
            stc_d = STB_W'(1);
          end
        end else begin
          vld_d = 1'b0;
          stc_d = '0;
        end
      end
      stb_d = (stc_d >= STB_W'(STABLE_SCANS));
    end

    // Per-digit state registers.
    always_ff @(posedge basys_clk or negedge reset_n) begin
      if (!reset_n) begin
        sym_q <= '0;
        vld_q <= 1'b0;
        stc_q <= '0;
        stb_q <= 1'b0;
      end else begin
        sym_q <= sym_d;
        vld_q <= vld_d;
        stc_q <= stc_d;
        stb_q <= stb_d;
      end
    end

    assign sym[g*SYM_W +: SYM_W] = sym_q;
    assign sym_valid[g]          = vld_q;
    assign digit_stable[g]       = stb_q;
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: expected frame snapshots are queued by the
// stimulus and checked by a monitor on every frame_done pulse.
module tb_seg_scan_decoder;

  logic        basys_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        err_clr;
  logic [11:0] sym;
  logic [3:0]  sym_valid;
  logic [3:0]  digit_stable;
  logic        frame_done;
  logic        anode_err;

  typedef struct packed {
    logic [11:0] sym;
    logic [3:0]  vld;
    logic [3:0]  stb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] T = 8'h87, C = 8'hC6, P = 8'h8C, L = 8'hC7;
  localparam logic [7:0] N = 8'hAB, O = 8'hC0, H = 8'h89, E = 8'h86;

  seg_scan_decoder #(.SETTLE_CYCLES(4), .STABLE_SCANS(3)) dut (
    .basys_clk    (basys_clk),
    .reset_n      (reset_n),
    .an           (an),
    .seg          (seg),
    .err_clr      (err_clr),
    .sym          (sym),
    .sym_valid    (sym_valid),
    .digit_stable (digit_stable),
    .frame_done   (frame_done),
    .anode_err    (anode_err)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge basys_clk);
    #1;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    cyc(n);
  endtask

  task automatic frame(input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3, input int n);
    dwell(4'b1110, g0, n);
    dwell(4'b1101, g1, n);
    dwell(4'b1011, g2, n);
    dwell(4'b0111, g3, n);
  endtask

  task automatic expect_frame(input logic [11:0] s, input logic [3:0] v, input logic [3:0] b);
    exp_t e;
    e.sym = s;
    e.vld = v;
    e.stb = b;
    exp_q.push_back(e);
  endtask

  // Monitor: each frame_done pulse consumes one queued snapshot.
  always @(negedge basys_clk) begin
    exp_t e;
    if (reset_n && frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_unexpected got 1 want 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("frame_sym", sym, e.sym);
        chk("frame_sym_valid", 12'(sym_valid), 12'(e.vld));
        chk("frame_digit_stable", 12'(digit_stable), 12'(e.stb));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    an      = 4'hF;
    seg     = 8'hFF;
    err_clr = 1'b0;
    cyc(3);
    chk("rst_sym", sym, 12'h000);
    chk("rst_sym_valid", 12'(sym_valid), 12'h0);
    chk("rst_digit_stable", 12'(digit_stable), 12'h0);
    chk("rst_frame_done", 12'(frame_done), 12'h0);
    chk("rst_anode_err", 12'(anode_err), 12'h0);
    reset_n = 1'b1;
    cyc(2);

    // T,C,P,L scan: stable after the third frame.
    expect_frame(12'h688, 4'hF, 4'h0);
    frame(T, C, P, L, 8);
    expect_frame(12'h688, 4'hF, 4'h0);
    frame(T, C, P, L, 8);
    expect_frame(12'h688, 4'hF, 4'hF);
    frame(T, C, P, L, 8);

    // Digit 2 flips H/E each frame and never becomes stable.
    expect_frame(12'h788, 4'hF, 4'hB);
    frame(T, C, H, L, 8);
    expect_frame(12'h7C8, 4'hF, 4'hB);
    frame(T, C, E, L, 8);
    expect_frame(12'h788, 4'hF, 4'hB);
    frame(T, C, H, L, 8);

    // Unknown glyph on digit 2: valid drops, symbol holds.
    expect_frame(12'h788, 4'hB, 4'hB);
    frame(T, C, 8'hFF, L, 8);
    dwell(4'hF, 8'hFF, 10);

    // Dwells one short of the settle time are never sampled.
    frame(N, O, N, O, 3);
    frame(N, O, N, O, 3);
    dwell(4'hF, 8'hFF, 10);
    chk("short_dwell_sym", sym, 12'h788);
    chk("short_dwell_valid", 12'(sym_valid), 12'hB);

    // Minimum sampled dwell: one sample per digit.
    expect_frame(12'hC2C, 4'hF, 4'h0);
    frame(N, O, T, H, 5);
    dwell(4'hF, 8'hFF, 10);

    // Invalid anode pattern raises the sticky error and takes no sample.
    chk("err_before", 12'(anode_err), 12'h0);
    dwell(4'b1100, T, 2);
    dwell(4'hF, 8'hFF, 4);
    chk("err_set", 12'(anode_err), 12'h1);
    chk("err_no_sample_sym", sym, 12'hC2C);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(2);
    chk("err_cleared", 12'(anode_err), 12'h0);

    // Clear coinciding with a new invalid anode: the error wins.
    an      = 4'b0000;
    err_clr = 1'b1;
    cyc(1);
    an      = 4'hF;
    cyc(1);
    err_clr = 1'b0;
    cyc(2);
    chk("err_beats_clear", 12'(anode_err), 12'h1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("err_cleared_again", 12'(anode_err), 12'h0);

    // Two frames, then reset in the middle of a third.
    expect_frame(12'h688, 4'hF, 4'h0);
    frame(T, C, P, L, 8);
    expect_frame(12'h688, 4'hF, 4'h0);
    frame(T, C, P, L, 8);
    dwell(4'b1110, T, 8);
    dwell(4'b1101, C, 8);
    dwell(4'b1011, P, 8);
    an  = 4'b0111;
    seg = L;
    cyc(2);
    reset_n = 1'b0;
    #1;
    chk("midrst_sym", sym, 12'h000);
    chk("midrst_sym_valid", 12'(sym_valid), 12'h0);
    chk("midrst_digit_stable", 12'(digit_stable), 12'h0);
    chk("midrst_frame_done", 12'(frame_done), 12'h0);
    chk("midrst_anode_err", 12'(anode_err), 12'h0);
    cyc(1);
    reset_n = 1'b1;

    // Fresh frame in reverse digit order: done only after all four samples.
    expect_frame(12'h688, 4'hF, 4'h0);
    dwell(4'b0111, L, 8);
    dwell(4'b1011, P, 8);
    dwell(4'b1101, C, 8);
    dwell(4'b1110, T, 8);
    dwell(4'hF, 8'hFF, 10);

    chk("pending_frames", 12'(exp_q.size()), 12'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
